bsg_mux2_rr_merge: RTL and testbench
====================================

# bsg_mux2_rr_merge

Two-input, packet-aware round-robin merger for a `width_p`-bit datapath. It decides each cycle which of two valid/ready producers drives a shared per-bit 2:1 select lane, with the grant replicated across all `width_p` select bits. The selected beat is captured in a one-entry output register. Once a producer wins, it keeps the grant until its packet's `last` beat is accepted. It sits wherever two streams share one downstream channel, such as a network injection port or a shared memory request port.

## Interface
- `width_p`, default 32: data width. Also the width of the internal per-bit select vector.
- `clk_i`, input, 1: clock. The single clock domain.
- `reset_i`, input, 1: synchronous, active-high reset.
- `v_i`, input, 2: per-producer valid. Bit k belongs to producer k.
- `last_i`, input, 2: per-producer end-of-packet flag. Meaningful only while `v_i[k]` is high.
- `data0_i`, input, `width_p`: producer 0 data.
- `data1_i`, input, `width_p`: producer 1 data.
- `ready_and_o`, output, 2: per-producer ready. A beat from producer k transfers when `v_i[k] & ready_and_o[k]`.
- `v_o`, output, 1: output valid. Registered.
- `data_o`, output, `width_p`: output data. Registered.
- `last_o`, output, 1: output end-of-packet flag. Registered.
- `src_o`, output, 1: index of the producer that supplied the current output beat. Registered.
- `ready_and_i`, input, 1: consumer ready. The output beat transfers when `v_o & ready_and_i`.

## Operation
- **State registers:**
  - `prio_r`: preferred producer.
  - `lock_r`: a packet is in progress.
  - `owner_r`: the locked producer.
  - The output register, holding `v_o`, `data_o`, `last_o`, `src_o`.
- **Enqueue permission:** `enq_ok = ~v_o | ready_and_i`. The output register accepts a new beat when it is empty or being drained in the same cycle.
- **Grant, combinational from `v_i` and state only (never from `ready_and_i`):**
  - If `lock_r`: `gnt = owner_r` when `v_i[owner_r]` is high. Otherwise there is no grant; the other producer is blocked even if it is valid.
  - If `~lock_r` and exactly one `v_i` bit is high: grant that producer.
  - If `~lock_r` and both are high: grant `prio_r`.
  - If `~lock_r` and none are high: no grant.
- **Ready:** `ready_and_o[k] = gnt_valid & (gnt == k) & enq_ok`. At most one bit is ever high.
- **Select lane:**
  - Select vector = `{width_p{gnt}}`.
  - Each bit picks `data1_i` when its select bit is 1, otherwise `data0_i`.
  - The result feeds the output register.
- **Accepted beat from producer k** (`v_i[k] & ready_and_o[k]`):
  - Load the output register with `v_o=1`, `data_o`=selected data, `last_o=last_i[k]`, `src_o=k`.
  - If `last_i[k]=0`: set `lock_r=1`, `owner_r=k`.
  - If `last_i[k]=1`: set `lock_r=0` and `prio_r=~k`, so the other producer is preferred next.
- **Drain without enqueue:** `v_o & ready_and_i` with no accepted input clears `v_o`. `data_o`, `last_o` and `src_o` hold their stale values.
- **Back-pressure:** while `v_o & ~ready_and_i`, all output-register fields hold and both `ready_and_o` bits are 0.
- **Single-beat packets** (`last_i=1` on the first beat) never set `lock_r`. Priority still alternates after each one.
- **Producer contract:** a producer must hold `data`/`last` stable while `v_i` is high and the beat is not yet accepted. The block relies on this and does not check it.
- **Combinational path:** `ready_and_o` depends on `v_i` within the same cycle. Producers must not derive `v_i` from `ready_and_o`.

## Timing
- **Reset values:** on `reset_i` at a clock edge:
  - `v_o=0`, `data_o=0`, `last_o=0`, `src_o=0`.
  - `lock_r=0`, `owner_r=0`, `prio_r=0` (producer 0 preferred first).
  - During the reset cycle, `ready_and_o=2'b00` regardless of `v_i`.
- **Reset mid-packet:** the lock is dropped and any held output beat is discarded with no flush. The first beat after reset is arbitrated fresh.
- **Latency:** a beat accepted in cycle t appears on `v_o`/`data_o` in cycle t+1.
- **Throughput:** one beat per cycle sustained while `ready_and_i=1`, including simultaneous enqueue and dequeue.
- **Arbitration update:**
  - `prio_r`, `lock_r` and `owner_r` update only on accepted beats.
  - Producer valid without acceptance never changes arbitration state.
- **Simultaneous events:** a `last` beat accepted while the other producer waits means the other producer is granted the next cycle, provided `enq_ok`.

## Test plan
- **Reset:** hold `reset_i` 2 cycles with `v_i=2'b11` -> `v_o=0`, `data_o=0`, `ready_and_o=00` throughout. First post-reset grant goes to producer 0.
- **Alternation:** both producers stream single-beat packets (`last=1`), `data0=0xA0000000+n`, `data1=0xB0000000+n`, `ready_and_i=1` -> `src_o` alternates 0,1,0,1 back-to-back, one beat per cycle, each value appearing 1 cycle after acceptance.
- **Packet lock:** producer 1 sends a 3-beat packet (`last=0,0,1`) while producer 0 is continuously valid -> three consecutive `src_o=1` beats, then `src_o=0`. `ready_and_o[0]=0` during the lock.
- **Back-pressure:** drop `ready_and_i` for 4 cycles with `v_o=1`, `data_o=0x12345678` -> `data_o`/`last_o`/`src_o` stable and `ready_and_o=00` for those 4 cycles. Resume without loss or duplication.
- **Per-bit select:** `data0=0x00000000`, `data1=0xFFFFFFFF`, alternating grants -> `data_o` exactly 0x00000000 or 0xFFFFFFFF, with no mixed bits.
- **Mid-packet reset:** assert reset after beat 1 of a producer-1 packet -> lock cleared. The next `v_i=2'b11` grants producer 0.

Source files
------------

// File: rtl/bsg_mux2_rr_merge.sv
// Two-input packet-aware round-robin merger feeding a one-entry output register.
// A producer that wins keeps the grant until its last beat is accepted.
module bsg_mux2_rr_merge #(
  parameter int unsigned width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         v_i,
  input  logic [1:0]         last_i,
  input  logic [width_p-1:0] data0_i,
  input  logic [width_p-1:0] data1_i,
  output logic [1:0]         ready_and_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               last_o,
  output logic               src_o,
  input  logic               ready_and_i
);

  logic               prio_q, prio_d;
  logic               lock_q, lock_d;
  logic               owner_q, owner_d;
  logic               v_q, v_d;
  logic [width_p-1:0] data_q, data_d;
  logic               last_q, last_d;
  logic               src_q, src_d;

  logic               gnt;
  logic               gnt_v;
  logic               enq_ok;
  logic               accept;
  logic               last_sel;
  logic [width_p-1:0] sel;
  logic [width_p-1:0] sel_data;

  assign enq_ok = ~v_q | ready_and_i;

  // Grant depends only on v_i and arbitration state, never on ready_and_i.
  always_comb begin
    gnt   = 1'b0;
    gnt_v = 1'b0;
    if (lock_q) begin
      gnt   = owner_q;
      gnt_v = owner_q ? v_i[1] : v_i[0];
    end else begin
      unique case (v_i)
        2'b01: begin
          gnt   = 1'b0;
          gnt_v = 1'b1;
        end
        2'b10: begin
          gnt   = 1'b1;
          gnt_v = 1'b1;
        end
        2'b11: begin
          gnt   = prio_q;
          gnt_v = 1'b1;
        end
        default: begin
          gnt   = 1'b0;
          gnt_v = 1'b0;
        end
      endcase
    end
  end

  assign accept = gnt_v & enq_ok;

  // Ready is forced low while reset is asserted so nothing looks accepted.
  assign ready_and_o[0] = ~reset_i & accept & ~gnt;
  assign ready_and_o[1] = ~reset_i & accept & gnt;

  assign sel      = {width_p{gnt}};
  assign sel_data = (sel & data1_i) | (~sel & data0_i);
  assign last_sel = gnt ? last_i[1] : last_i[0];

  always_comb begin
    v_d     = v_q;
    data_d  = data_q;
    last_d  = last_q;
    src_d   = src_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    if (accept) begin
      v_d    = 1'b1;
      data_d = sel_data;
      last_d = last_sel;
      src_d  = gnt;
      if (last_sel) begin
        lock_d = 1'b0;
        prio_d = ~gnt;
      end else begin
        lock_d  = 1'b1;
        owner_d = gnt;
      end
    end else if (v_q & ready_and_i) begin
      // Drain only: payload fields keep their stale values.
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q     <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      src_q   <= 1'b0;
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      v_q     <= v_d;
      data_q  <= data_d;
      last_q  <= last_d;
      src_q   <= src_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign last_o = last_q;
  assign src_o  = src_q;

endmodule

// File: tb/tb_bsg_mux2_rr_merge.sv
// Directed bench for bsg_mux2_rr_merge: reset, alternation, packet lock,
// back-pressure, per-bit select and mid-packet reset.
module tb_bsg_mux2_rr_merge;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [1:0]  v_i;
  logic [1:0]  last_i;
  logic [31:0] data0_i;
  logic [31:0] data1_i;
  logic [1:0]  ready_and_o;
  logic        v_o;
  logic [31:0] data_o;
  logic        last_o;
  logic        src_o;
  logic        ready_and_i;

  int n_tests = 0;
  int n_fail  = 0;

  bsg_mux2_rr_merge #(.width_p(32)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .v_i        (v_i),
    .last_i     (last_i),
    .data0_i    (data0_i),
    .data1_i    (data1_i),
    .ready_and_o(ready_and_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .last_o     (last_o),
    .src_o      (src_o),
    .ready_and_i(ready_and_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat per cycle from alternating producers, expected src = n parity.
  task automatic alt_beats(input string tag, input int count, input logic [31:0] b0,
                           input logic [31:0] b1, input logic add_n);
    logic [31:0] e0, e1;
    for (int n = 0; n < count; n++) begin
      e0 = add_n ? b0 + n : b0;
      e1 = add_n ? b1 + n : b1;
      data0_i = e0;
      data1_i = e1;
      #1;
      check({tag, "_rdy"}, {30'd0, ready_and_o}, (n % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check({tag, "_v"}, {31'd0, v_o}, 32'd1);
      check({tag, "_src"}, {31'd0, src_o}, (n % 2 == 0) ? 32'd0 : 32'd1);
      check({tag, "_data"}, data_o, (n % 2 == 0) ? e0 : e1);
      check({tag, "_last"}, {31'd0, last_o}, 32'd1);
    end
  endtask

  initial begin
    reset_i     = 1'b1;
    v_i         = 2'b11;
    last_i      = 2'b11;
    data0_i     = 32'hA000_0000;
    data1_i     = 32'hB000_0000;
    ready_and_i = 1'b1;

    // Reset held two cycles with both producers valid.
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_rdy", {30'd0, ready_and_o}, 32'd0);
      tick();
      check("rst_v", {31'd0, v_o}, 32'd0);
      check("rst_data", data_o, 32'd0);
      check("rst_last", {31'd0, last_o}, 32'd0);
      check("rst_src", {31'd0, src_o}, 32'd0);
    end
    reset_i = 1'b0;

    // Single-beat packets alternate starting with producer 0.
    alt_beats("alt", 6, 32'hA000_0000, 32'hB000_0000, 1'b1);
    // Per-bit select: output must be all zeros or all ones.
    alt_beats("sel", 4, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);

    // Packet lock: producer 1 sends 3 beats while producer 0 waits.
    v_i = 2'b10; last_i = 2'b10; data1_i = 32'hC000_0001;
    last_i = 2'b00;
    #1;
    check("lock_rdy1", {30'd0, ready_and_o}, 32'd2);
    tick();
    check("lock_src1", {31'd0, src_o}, 32'd1);
    check("lock_data1", data_o, 32'hC000_0001);
    check("lock_last1", {31'd0, last_o}, 32'd0);
    v_i = 2'b11; last_i = 2'b01; data0_i = 32'hD000_0000; data1_i = 32'hC000_0002;
    #1;
    check("lock_rdy2", {30'd0, ready_and_o}, 32'd2);
    tick();
    check("lock_src2", {31'd0, src_o}, 32'd1);
    check("lock_data2", data_o, 32'hC000_0002);
    last_i = 2'b11; data1_i = 32'hC000_0003;
    #1;
    check("lock_rdy3", {30'd0, ready_and_o}, 32'd2);
    tick();
    check("lock_src3", {31'd0, src_o}, 32'd1);
    check("lock_last3", {31'd0, last_o}, 32'd1);
    #1;
    check("unlock_rdy", {30'd0, ready_and_o}, 32'd1);
    tick();
    check("unlock_src", {31'd0, src_o}, 32'd0);
    check("unlock_data", data_o, 32'hD000_0000);

    // Back-pressure: prio now prefers producer 1.
    v_i = 2'b01; last_i = 2'b11; data0_i = 32'h1234_5678;
    #1;
    check("bp_rdy0", {30'd0, ready_and_o}, 32'd1);
    tick();
    check("bp_data0", data_o, 32'h1234_5678);
    ready_and_i = 1'b0;
    v_i = 2'b11; data0_i = 32'hDEAD_0001; data1_i = 32'hBEEF_0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_rdy", {30'd0, ready_and_o}, 32'd0);
      tick();
      check("bp_v", {31'd0, v_o}, 32'd1);
      check("bp_data", data_o, 32'h1234_5678);
      check("bp_src", {31'd0, src_o}, 32'd0);
      check("bp_last", {31'd0, last_o}, 32'd1);
    end
    ready_and_i = 1'b1;
    #1;
    check("bp_resume_rdy", {30'd0, ready_and_o}, 32'd2);
    tick();
    check("bp_resume_data", data_o, 32'hBEEF_0001);
    check("bp_resume_src", {31'd0, src_o}, 32'd1);
    v_i = 2'b00;
    #1;
    check("drain_rdy", {30'd0, ready_and_o}, 32'd0);
    tick();
    check("drain_v", {31'd0, v_o}, 32'd0);
    check("drain_stale", data_o, 32'hBEEF_0001);

    // Mid-packet reset: prio prefers producer 0 again; open a producer-1 packet.
    v_i = 2'b10; last_i = 2'b00; data1_i = 32'hE000_0001;
    #1;
    check("mpr_rdy1", {30'd0, ready_and_o}, 32'd2);
    tick();
    check("mpr_src1", {31'd0, src_o}, 32'd1);
    v_i = 2'b01; last_i = 2'b11;
    #1;
    check("mpr_locked", {30'd0, ready_and_o}, 32'd0);
    tick();
    reset_i = 1'b1; v_i = 2'b11;
    #1;
    check("mpr_rst_rdy", {30'd0, ready_and_o}, 32'd0);
    tick();
    check("mpr_rst_v", {31'd0, v_o}, 32'd0);
    check("mpr_rst_data", data_o, 32'd0);
    reset_i = 1'b0; data0_i = 32'hF000_0000;
    #1;
    check("mpr_post_rdy", {30'd0, ready_and_o}, 32'd1);
    tick();
    check("mpr_post_src", {31'd0, src_o}, 32'd0);
    check("mpr_post_data", data_o, 32'hF000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
